rr_arbiter8: RTL and testbench

- 8-requester round-robin arbiter for one shared resource.
- Issues a registered one-hot grant (the 3-to-8 decoded form of the winner index) plus the binary index.
- Sits in front of any shared combinational unit, e.g. a decoder-driven output bank, so that only one requester drives it at a time.
- Enforces fair rotation and a bounded hold time per grant.

---
 rtl/rr_arbiter8.sv | 106 ++++++++++
 tb/tb_rr_arbiter8.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant, binary index and
// bounded hold time; a forced release pulses timeout for one cycle.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [7:0]    grant_q, grant_d;
    logic          timeout_q, timeout_d;

    logic [15:0]   req_dbl;
    logic [7:0]    req_rot;
    logic [2:0]    win_off;
    logic [2:0]    winner;
    logic          any_req;
    logic          user_rel;
    logic          hold_max;

    // Rotate so that bit 0 of req_rot is the requester at ptr; lowest set bit wins.
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[7:0];
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
        winner  = ptr_q + win_off;
        any_req = |req;
    end

    assign user_rel = done || !req[idx_q];
    assign hold_max = (hold_q == CW'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en && any_req) begin
                    state_d = StGrant;
                    idx_d   = winner;
                    grant_d = 8'b1 << winner;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (user_rel || hold_max) begin
                    state_d   = StIdle;
                    grant_d   = 8'b0;
                    ptr_d     = idx_q + 3'd1;
                    // A normal release always wins over a coincident hold expiry.
                    timeout_d = !user_rel;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            hold_q    <= '0;
            grant_q   <= 8'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == StGrant);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios with literal expectations plus a random
// phase checked every cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       done = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter8 #(.MAX_HOLD(MAXH), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner number, cycles the grant has been visible, next priority.
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_held;
    bit m_to;
    bit m_userrel;
    bit m_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_busy) begin
                m_userrel = done || !req[m_idx];
                if (m_userrel || m_held == MAXH) begin
                    m_to   = !m_userrel;
                    m_busy = 0;
                    m_ptr  = (m_idx + 1) % 8;
                end else begin
                    m_held++;
                end
            end else if (en && req != 8'h00) begin
                m_found = 0;
                for (int i = 0; i < 8; i++) begin
                    if (!m_found && req[(m_ptr + i) % 8]) begin
                        m_idx   = (m_ptr + i) % 8;
                        m_found = 1;
                    end
                end
                m_busy = 1;
                m_held = 1;
            end
        end
    end

    logic [7:0] m_grant;
    always @(negedge clk) begin
        if (rst_n) begin
            m_grant = 8'h00;
            if (m_busy) m_grant[m_idx] = 1'b1;
            chk("model.grant", 32'(grant), 32'(m_grant));
            chk("model.gnt_idx", 32'(gnt_idx), 32'(m_idx));
            chk("model.gnt_valid", 32'(gnt_valid), 32'(m_busy));
            chk("model.timeout", 32'(timeout), 32'(m_to));
        end
    end

    task automatic drive(input logic [7:0] r, input logic e, input logic d);
        req = r; en = e; done = d;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic t);
        chk({nm, ".grant"}, 32'(grant), 32'(g));
        chk({nm, ".gnt_idx"}, 32'(gnt_idx), 32'(i));
        chk({nm, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        chk({nm, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    logic [7:0] r_rand;
    logic       e_rand;
    logic       d_rand;
    int         d_pct;

    initial begin
        rst_n = 1'b0;
        #12;
        lit("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic grant and release; ptr moves to 1.
        drive(8'h01, 1, 0); lit("t1_grant", 8'h01, 3'd0, 1, 0);
        drive(8'h01, 1, 1); lit("t1_release", 8'h00, 3'd0, 0, 0);

        // Rotation between 2 and 7 with wrap back to 2.
        drive(8'h84, 1, 0); lit("t2_g2", 8'h04, 3'd2, 1, 0);
        drive(8'h84, 1, 1); lit("t2_idle1", 8'h00, 3'd2, 0, 0);
        drive(8'h84, 1, 0); lit("t2_g7", 8'h80, 3'd7, 1, 0);
        drive(8'h84, 1, 1); lit("t2_idle2", 8'h00, 3'd7, 0, 0);
        drive(8'h84, 1, 0); lit("t2_g2b", 8'h04, 3'd2, 1, 0);
        drive(8'h84, 1, 1); lit("t2_idle3", 8'h00, 3'd2, 0, 0);

        // Hold limit: exactly MAXH cycles, then timeout pulse, then idle-separated regrant.
        drive(8'h10, 1, 0); lit("t3_g4", 8'h10, 3'd4, 1, 0);
        for (int k = 2; k <= MAXH; k++) begin
            drive(8'h10, 1, 0); lit("t3_hold", 8'h10, 3'd4, 1, 0);
        end
        drive(8'h10, 1, 0); lit("t3_timeout", 8'h00, 3'd4, 0, 1);
        drive(8'h10, 1, 0); lit("t3_regrant", 8'h10, 3'd4, 1, 0);
        drive(8'h00, 1, 0); lit("t3_drop", 8'h00, 3'd4, 0, 0);

        // Enable gating; reset pulse first so ptr is 0.
        rst_n = 1'b0;
        #1;
        lit("t4_rst", 8'h00, 3'd0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(8'hFF, 0, 0); lit("t4_blocked", 8'h00, 3'd0, 0, 0);
        end
        drive(8'hFF, 1, 0); lit("t4_g0", 8'h01, 3'd0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(8'hFF, 0, 0); lit("t4_persist", 8'h01, 3'd0, 1, 0);
        end
        drive(8'hFF, 0, 1); lit("t4_done", 8'h00, 3'd0, 0, 0);
        drive(8'hFF, 0, 0); lit("t4_held_off", 8'h00, 3'd0, 0, 0);

        // Owner drops its request; then done coincident with hold expiry.
        drive(8'h08, 1, 0); lit("t5_g3", 8'h08, 3'd3, 1, 0);
        drive(8'h00, 1, 0); lit("t5_drop", 8'h00, 3'd3, 0, 0);
        drive(8'h18, 1, 0); lit("t5_ptr4", 8'h10, 3'd4, 1, 0);
        for (int k = 2; k <= MAXH; k++) begin
            drive(8'h18, 1, 0); lit("t5_hold", 8'h10, 3'd4, 1, 0);
        end
        drive(8'h18, 1, 1); lit("t5_done_at_limit", 8'h00, 3'd4, 0, 0);

        // Asynchronous reset mid-grant.
        drive(8'h20, 1, 0); lit("t6_g5", 8'h20, 3'd5, 1, 0);
        #2 rst_n = 1'b0;
        #1 lit("t6_async", 8'h00, 3'd0, 0, 0);
        @(negedge clk);
        req = 8'h21; en = 1'b1; done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        lit("t6_after", 8'h01, 3'd0, 1, 0);

        // Random phase; blocks alternate between no done (forces timeouts) and frequent done.
        r_rand = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            d_pct = ((c / 150) % 2 == 0) ? 0 : 25;
            if ($urandom_range(3) == 0) r_rand = 8'($urandom);
            e_rand = ($urandom_range(7) != 0);
            d_rand = ($urandom_range(99) < d_pct);
            if ($urandom_range(599) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            drive(r_rand, e_rand, d_rand);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
